fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter packing narrow requester beats into a wide FIFO.
// Each grant is a full BEATS-beat burst so every wide word has one source.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 4,
  parameter int BEATS = 4,
  localparam int OW = $clog2(NREQ),
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               fifo_wen,
  output logic [DW-1:0]      fifo_wdata,
  input  logic               fifo_full,
  input  logic               fifo_prog_full,
  output logic               busy,
  output logic [OW-1:0]      owner,
  output logic               burst_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q;
  logic [OW-1:0] owner_q;
  logic [BW-1:0] beat_q;
  logic [OW-1:0] rr_ptr_q;
  logic          done_q;

  logic [DW-1:0] slice [NREQ];
  logic [OW-1:0] sel;
  logic [OW-1:0] idx;
  logic          start;
  logic          accept;
  logic          last;
  logic [OW-1:0] owner_nxt;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slice[g] = req_data[g*DW +: DW];
  end

  // Highest offset first, so the lowest offset from rr_ptr wins.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = OW'((int'(rr_ptr_q) + i) % NREQ);
      if (req[idx]) sel = idx;
    end
  end

  assign busy   = (state_q == BURST);
  assign start  = !busy && (|req) && !fifo_prog_full;
  assign accept = busy && req[owner_q] && !fifo_full;
  assign last   = (beat_q == BW'(BEATS - 1));

  assign owner_nxt = (owner_q == OW'(NREQ - 1)) ?
                     '0 : owner_q + 1'b1;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = accept && (owner_q == OW'(i));
    end
  end

  assign fifo_wen   = accept;
  assign fifo_wdata = busy ? slice[owner_q] : '0;
  assign owner      = owner_q;
  assign burst_done = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      beat_q   <= '0;
      rr_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            owner_q <= sel;
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_q <= last ? '0 : beat_q + 1'b1;
            if (last) begin
              state_q  <= IDLE;
              rr_ptr_q <= owner_nxt;
              done_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, round robin,
// full stall, prog_full gating, owner drop and mid-burst reset.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 4;
  localparam int BEATS = 4;
  localparam int OW    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               fifo_wen;
  logic [DW-1:0]      fifo_wdata;
  logic               fifo_full;
  logic               fifo_prog_full;
  logic               busy;
  logic [OW-1:0]      owner;
  logic               burst_done;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .BEATS(BEATS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_wen      (fifo_wen),
    .fifo_wdata    (fifo_wdata),
    .fifo_full     (fifo_full),
    .fifo_prog_full(fifo_prog_full),
    .busy          (busy),
    .owner         (owner),
    .burst_done    (burst_done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Inputs are already set; checks the quiet IDLE outputs.
  task automatic idle_chk(input string tag,
                          input logic done);
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wen"},  32'(fifo_wen), 32'd0);
    chk({tag, "_gnt"},  32'(gnt), 32'd0);
    chk({tag, "_wd"},   32'(fifo_wdata), 32'd0);
    chk({tag, "_done"}, 32'(burst_done), 32'(done));
  endtask

  task automatic beat(input string tag,
                      input int o,
                      input logic [DW-1:0] d);
    req_data[o*DW +: DW] = d;
    #1;
    chk({tag, "_wen"},   32'(fifo_wen), 32'd1);
    chk({tag, "_wd"},    32'(fifo_wdata), 32'(d));
    chk({tag, "_gnt"},   32'(gnt), 32'(1 << o));
    chk({tag, "_owner"}, 32'(owner), 32'(o));
    chk({tag, "_busy"},  32'(busy), 32'd1);
    cyc();
  endtask

  task automatic stall(input string tag, input int o);
    #1;
    chk({tag, "_wen"},   32'(fifo_wen), 32'd0);
    chk({tag, "_gnt"},   32'(gnt), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'(o));
    chk({tag, "_busy"},  32'(busy), 32'd1);
    cyc();
  endtask

  task automatic burst(input string tag, input int o);
    for (int k = 0; k < BEATS; k++) begin
      beat(tag, o, DW'(o * 4 + k));
    end
  endtask

  initial begin
    rst            = 1'b1;
    req            = '0;
    req_data       = '0;
    fifo_full      = 1'b0;
    fifo_prog_full = 1'b0;
    cyc();
    cyc();
    idle_chk("rst", 1'b0);
    chk("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    cyc();

    // Solo requester, back-to-back bursts with a one-cycle bubble
    req = 4'b0001;
    idle_chk("solo_req", 1'b0);
    cyc();
    beat("solo_b1", 0, 4'd1);
    beat("solo_b2", 0, 4'd2);
    beat("solo_b3", 0, 4'd3);
    beat("solo_b4", 0, 4'd4);
    idle_chk("solo_bub", 1'b1);
    chk("solo_bub_owner", 32'(owner), 32'd0);
    cyc();
    chk("solo_again_done", 32'(burst_done), 32'd0);
    burst("solo2", 0);
    req = '0;
    idle_chk("solo2_bub", 1'b1);
    cyc();
    idle_chk("solo_quiet", 1'b0);

    // Round robin from a fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 4'b1111;
    cyc();
    burst("rr0", 0);
    idle_chk("rr0_bub", 1'b1);
    cyc();
    burst("rr1", 1);
    idle_chk("rr1_bub", 1'b1);
    cyc();
    burst("rr2", 2);
    idle_chk("rr2_bub", 1'b1);
    cyc();
    burst("rr3", 3);
    idle_chk("rr3_bub", 1'b1);
    cyc();
    burst("rr4", 0);
    req = '0;
    idle_chk("rr4_bub", 1'b1);
    cyc();

    // fifo_full stall after beat 2 (rr_ptr now 1)
    req = 4'b0010;
    cyc();
    beat("full_b1", 1, 4'h5);
    beat("full_b2", 1, 4'h6);
    fifo_full = 1'b1;
    stall("full_s1", 1);
    stall("full_s2", 1);
    stall("full_s3", 1);
    fifo_full = 1'b0;
    beat("full_b3", 1, 4'h7);
    beat("full_b4", 1, 4'h8);
    req = '0;
    idle_chk("full_bub", 1'b1);
    cyc();

    // prog_full blocks a start but not a running burst
    fifo_prog_full = 1'b1;
    req = 4'b0010;
    idle_chk("pf_blk1", 1'b0);
    cyc();
    idle_chk("pf_blk2", 1'b0);
    cyc();
    idle_chk("pf_blk3", 1'b0);
    fifo_prog_full = 1'b0;
    cyc();
    beat("pf_b1", 1, 4'h9);
    fifo_prog_full = 1'b1;
    beat("pf_b2", 1, 4'hA);
    beat("pf_b3", 1, 4'hB);
    beat("pf_b4", 1, 4'hC);
    idle_chk("pf_bub", 1'b1);
    cyc();
    idle_chk("pf_nostart", 1'b0);
    fifo_prog_full = 1'b0;
    req = '0;
    cyc();

    // Owner drops mid-burst while req[2] waits (rr_ptr now 2)
    req = 4'b0001;
    cyc();
    beat("drop_b1", 0, 4'h1);
    beat("drop_b2", 0, 4'h2);
    req = 4'b0100;
    stall("drop_s1", 0);
    stall("drop_s2", 0);
    req = 4'b0101;
    beat("drop_b3", 0, 4'h3);
    beat("drop_b4", 0, 4'h4);
    idle_chk("drop_bub", 1'b1);
    cyc();
    chk("drop_next_owner", 32'(owner), 32'd2);

    // Reset mid-burst after two beats of owner 2
    beat("rmb_b1", 2, 4'hD);
    beat("rmb_b2", 2, 4'hE);
    rst = 1'b1;
    idle_chk("rmb_async", 1'b0);
    chk("rmb_owner", 32'(owner), 32'd0);
    cyc();
    rst = 1'b0;
    req = 4'b0100;
    idle_chk("rmb_rel", 1'b0);
    cyc();
    beat("rmb_n1", 2, 4'h1);
    beat("rmb_n2", 2, 4'h2);
    beat("rmb_n3", 2, 4'h3);
    beat("rmb_n4", 2, 4'h4);
    req = '0;
    idle_chk("rmb_bub", 1'b1);
    cyc();
    idle_chk("end_quiet", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
